// File: rtl/tcdm_arb_pkg.sv
// Shared types and helpers for the N:1 round-robin TCDM arbiter.
package tcdm_arb_pkg;

    // Default requester count; the arbiter can be built with any NB_REQ up to ARB_MAX_REQ.
    localparam int unsigned ARB_NB_REQ    = 4;
    localparam int unsigned ARB_MAX_REQ   = 64;
    localparam int unsigned ARB_MAX_IDX_W = $clog2(ARB_MAX_REQ);

    typedef logic [$clog2(ARB_NB_REQ)-1:0] idx_t;

    // Wrap-around priority search: first set bit of req[n-1:0] at or after ptr.
    // Returns 0 when nothing is set, so an idle arbiter muxes requester 0.
    function automatic int unsigned rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                            input int unsigned           ptr,
                                            input int unsigned           n);
        int unsigned pos;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < ARB_MAX_REQ; k++) begin
            pos = ptr + k;
            if (pos >= n) pos = pos - n;
            if ((k < n) && !found && req[ARB_MAX_IDX_W'(pos)]) begin
                rr_pick = pos;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/tcdm_arb_id_fifo.sv
// In-order ID FIFO: remembers which requester owns each granted transaction.
// Push while full and pop while empty are ignored; full/empty depend on registers only.
module tcdm_arb_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_q];

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps the count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/tcdm_rr_arbiter_nx1.sv
// N:1 round-robin arbiter sharing one TCDM master port, with up to
// MAX_OUTSTANDING pipelined transactions routed back through an ID FIFO.
//
// Handshake: req is the valid, gnt the ready. A transfer happens in any cycle
// where req_o & gnt_i; the payload must stay stable from the first cycle req_o
// is high until that transfer, which the lock flag guarantees. Responses carry
// no ready: r_valid_i is accepted unconditionally, in order, one per transfer.
module tcdm_rr_arbiter_nx1
    import tcdm_arb_pkg::*;
#(
    parameter int unsigned NB_REQ          = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NB_REQ-1:0]                   req_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]   add_i,
    input  logic [NB_REQ-1:0]                   wen_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]   wdata_i,
    input  logic [NB_REQ-1:0][BE_WIDTH-1:0]     be_i,
    output logic [NB_REQ-1:0]                   gnt_o,
    output logic [NB_REQ-1:0]                   r_valid_o,
    output logic [NB_REQ-1:0]                   r_opc_o,
    output logic [DATA_WIDTH-1:0]               r_rdata_o,
    output logic                                req_o,
    output logic [ADDR_WIDTH-1:0]               add_o,
    output logic                                wen_o,
    output logic [DATA_WIDTH-1:0]               wdata_o,
    output logic [BE_WIDTH-1:0]                 be_o,
    input  logic                                gnt_i,
    input  logic                                r_valid_i,
    input  logic                                r_opc_i,
    input  logic [DATA_WIDTH-1:0]               r_rdata_i
);
    localparam int unsigned IDX_W = $clog2(NB_REQ);

    logic [IDX_W-1:0]       ptr_q, sel_q, sel, rr_sel, ptr_nxt, head;
    logic                   lock_q;
    logic                   fifo_full, fifo_empty;
    logic                   hs, pop;
    logic [ARB_MAX_REQ-1:0] req_vec;

    // Widen the request vector to the search function's fixed width.
    always_comb begin
        req_vec             = '0;
        req_vec[NB_REQ-1:0] = req_i;
    end

    assign rr_sel  = IDX_W'(rr_pick(req_vec, 32'(ptr_q), NB_REQ));
    assign sel     = lock_q ? sel_q : rr_sel;
    assign req_o   = (|req_i) & ~fifo_full;
    assign hs      = req_o & gnt_i;
    assign ptr_nxt = (sel == IDX_W'(NB_REQ - 1)) ? '0 : sel + 1'b1;
    assign pop     = r_valid_i & ~fifo_empty;

    assign add_o     = add_i[sel];
    assign wen_o     = wen_i[sel];
    assign wdata_o   = wdata_i[sel];
    assign be_o      = be_i[sel];
    assign r_rdata_o = r_rdata_i;

    // Grant goes only to the selected requester, and only on a real transfer.
    always_comb begin
        gnt_o = '0;
        if (hs) gnt_o[sel] = 1'b1;
    end

    // Route the response to the owner of the oldest outstanding transaction.
    always_comb begin
        r_valid_o = '0;
        r_opc_o   = '0;
        if (!fifo_empty) begin
            r_valid_o[head] = r_valid_i;
            r_opc_o[head]   = r_opc_i;
        end
    end

    // RR pointer advances past each winner; lock freezes sel while a request waits for grant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q  <= '0;
            lock_q <= 1'b0;
            sel_q  <= '0;
        end else begin
            if (hs) ptr_q <= ptr_nxt;
            if (lock_q && !req_i[sel_q]) begin
                lock_q <= 1'b0;
            end else if (req_o && !gnt_i) begin
                lock_q <= 1'b1;
                sel_q  <= sel;
            end else begin
                lock_q <= 1'b0;
            end
        end
    end

    tcdm_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (sel),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A locked requester must hold its request until granted.
    a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> req_i[sel_q]);

    // Every response must belong to an outstanding transaction.
    a_rsp_owned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_valid_i |-> !fifo_empty);

endmodule

// File: tb/tb_tcdm_rr_arbiter_nx1.sv
// Directed bench for tcdm_rr_arbiter_nx1 (NB_REQ=4, MAX_OUTSTANDING=2).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_tcdm_rr_arbiter_nx1;

    localparam int NB = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NB-1:0]         req;
    logic [NB-1:0][AW-1:0] add;
    logic [NB-1:0]         wen;
    logic [NB-1:0][DW-1:0] wdata;
    logic [NB-1:0][BW-1:0] be;
    logic [NB-1:0]         gnt_o, r_valid_o, r_opc_o;
    logic [DW-1:0]         r_rdata_o;
    logic                  req_o, wen_o;
    logic [AW-1:0]         add_o;
    logic [DW-1:0]         wdata_o;
    logic [BW-1:0]         be_o;
    logic                  gnt_i, r_valid_i, r_opc_i;
    logic [DW-1:0]         r_rdata_i;

    logic [NB-1:0] wen_pat;

    tcdm_rr_arbiter_nx1 #(
        .NB_REQ          (NB),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .BE_WIDTH        (BW),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .add_i     (add),
        .wen_i     (wen),
        .wdata_i   (wdata),
        .be_i      (be),
        .gnt_o     (gnt_o),
        .r_valid_o (r_valid_o),
        .r_opc_o   (r_opc_o),
        .r_rdata_o (r_rdata_o),
        .req_o     (req_o),
        .add_o     (add_o),
        .wen_o     (wen_o),
        .wdata_o   (wdata_o),
        .be_o      (be_o),
        .gnt_i     (gnt_i),
        .r_valid_i (r_valid_i),
        .r_opc_i   (r_opc_i),
        .r_rdata_i (r_rdata_i)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [NB-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h40;
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic logic [BW-1:0] be_of(input int i);
        return 4'b0001 << i;
    endfunction

    task automatic expect_rsp(input logic [NB-1:0] onehot);
        exp_q.push_back(onehot);
    endtask

    task automatic check_rsp(input string tag);
        logic [NB-1:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk(tag, 32'(r_valid_o), 32'(e));
    endtask

    task automatic chk_payload(input int i, input string tag);
        chk({tag, "_add"},   add_o,         addr_of(i));
        chk({tag, "_wdata"}, wdata_o,       wdata_of(i));
        chk({tag, "_be"},    32'(be_o),     32'(be_of(i)));
        chk({tag, "_wen"},   32'(wen_o),    32'(wen_pat[i]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive(input logic [NB-1:0] r, input logic g, input logic v,
                         input logic o, input logic [DW-1:0] d);
        req       = r;
        gnt_i     = g;
        r_valid_i = v;
        r_opc_i   = o;
        r_rdata_i = d;
    endtask

    task automatic load_payload;
        for (int i = 0; i < NB; i++) begin
            add[i]   = addr_of(i);
            wdata[i] = wdata_of(i);
            be[i]    = be_of(i);
        end
        wen = wen_pat;
    endtask

    task automatic reset_dut;
        tick;
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0, 1'b0, '0);
        tick;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        wen_pat = 4'b0101;
        rst_n   = 1'b0;
        add     = '0;
        wdata   = '0;
        be      = '0;
        wen     = '0;
        drive('0, 1'b0, 1'b0, 1'b0, '0);

        // Reset state: all outputs zero with zero inputs.
        tick;
        #1;
        chk("rst_gnt",    32'(gnt_o),     32'h0);
        chk("rst_rvalid", 32'(r_valid_o), 32'h0);
        chk("rst_ropc",   32'(r_opc_o),   32'h0);
        chk("rst_rdata",  r_rdata_o,      32'h0);
        chk("rst_req",    32'(req_o),     32'h0);
        chk("rst_add",    add_o,          32'h0);
        chk("rst_wen",    32'(wen_o),     32'h0);
        chk("rst_wdata",  wdata_o,        32'h0);
        chk("rst_be",     32'(be_o),      32'h0);
        tick;
        rst_n = 1'b1;
        load_payload;
        #1;
        chk_payload(0, "idle");

        // T1: single read from requester 2, response one cycle later.
        tick; drive(4'b0100, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t1_gnt", 32'(gnt_o), 32'h4);
        chk("t1_req", 32'(req_o), 32'h1);
        chk_payload(2, "t1");
        expect_rsp(4'b0100);
        tick; drive('0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF); #1;
        check_rsp("t1_rsp");
        chk("t1_rdata", r_rdata_o, 32'hDEADBEEF);
        chk("t1_gnt_idle", 32'(gnt_o), 32'h0);
        chk("t1_opc", 32'(r_opc_o), 32'h0);
        tick; drive('0, 1'b0, 1'b0, 1'b0, '0); #1;
        chk("t1_rsp_done", 32'(r_valid_o), 32'h0);

        // T2: all four requesting, grant order must be 0,1,2,3,0,1,2,3.
        reset_dut;
        for (int k = 0; k < 8; k++) begin
            logic [NB-1:0] g;
            g = 4'b0001 << (k % 4);
            tick; drive(4'b1111, 1'b1, k > 0, 1'b0, 32'h100 + 32'(k)); #1;
            chk($sformatf("t2_gnt%0d", k), 32'(gnt_o), 32'(g));
            chk_payload(k % 4, $sformatf("t2_pl%0d", k));
            if (k > 0) check_rsp($sformatf("t2_rsp%0d", k));
            expect_rsp(g);
        end
        tick; drive('0, 1'b0, 1'b1, 1'b0, '0); #1;
        check_rsp("t2_rsp8");
        tick; drive('0, 1'b0, 1'b0, 1'b0, '0);

        // T3: lock keeps requester 1's payload while 3 competes and gnt_i is low.
        reset_dut;
        tick; drive(4'b0010, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t3_pre_gnt", 32'(gnt_o), 32'h2);
        expect_rsp(4'b0010);
        tick; drive(4'b0010, 1'b0, 1'b1, 1'b0, '0); #1;
        check_rsp("t3_pre_rsp");
        chk("t3_a_gnt", 32'(gnt_o), 32'h0);
        chk_payload(1, "t3_a");
        for (int c = 0; c < 2; c++) begin
            tick; drive(4'b1010, 1'b0, 1'b0, 1'b0, '0); #1;
            chk($sformatf("t3_hold_gnt%0d", c), 32'(gnt_o), 32'h0);
            chk_payload(1, $sformatf("t3_hold%0d", c));
        end
        tick; drive(4'b1010, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t3_gnt1", 32'(gnt_o), 32'h2);
        chk_payload(1, "t3_d");
        expect_rsp(4'b0010);
        tick; drive(4'b1000, 1'b1, 1'b1, 1'b0, '0); #1;
        check_rsp("t3_rsp1");
        chk("t3_gnt3", 32'(gnt_o), 32'h8);
        chk_payload(3, "t3_e");
        expect_rsp(4'b1000);
        tick; drive('0, 1'b0, 1'b1, 1'b0, '0); #1;
        check_rsp("t3_rsp3");
        tick; drive('0, 1'b0, 1'b0, 1'b0, '0);

        // T4: two outstanding fill the FIFO; a same-cycle pop does not unblock.
        reset_dut;
        tick; drive(4'b0001, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t4_gnt0", 32'(gnt_o), 32'h1);
        expect_rsp(4'b0001);
        tick; drive(4'b0010, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t4_gnt1", 32'(gnt_o), 32'h2);
        expect_rsp(4'b0010);
        tick; drive(4'b0100, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t4_full_req", 32'(req_o), 32'h0);
        chk("t4_full_gnt", 32'(gnt_o), 32'h0);
        tick; drive(4'b0100, 1'b1, 1'b1, 1'b0, '0); #1;
        chk("t4_pop_req", 32'(req_o), 32'h0);
        chk("t4_pop_gnt", 32'(gnt_o), 32'h0);
        check_rsp("t4_rsp0");
        tick; drive(4'b0100, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t4_resume_req", 32'(req_o), 32'h1);
        chk("t4_resume_gnt", 32'(gnt_o), 32'h4);
        expect_rsp(4'b0100);
        tick; drive('0, 1'b0, 1'b1, 1'b0, '0); #1;
        check_rsp("t4_rsp1");
        tick; drive('0, 1'b0, 1'b1, 1'b0, '0); #1;
        check_rsp("t4_rsp2");
        tick; drive('0, 1'b0, 1'b0, 1'b0, '0);

        // T5: grant and response together at occupancy 1.
        reset_dut;
        tick; drive(4'b0100, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t5_gnt2", 32'(gnt_o), 32'h4);
        expect_rsp(4'b0100);
        tick; drive(4'b1000, 1'b1, 1'b1, 1'b1, 32'h5555_AAAA); #1;
        check_rsp("t5_rsp2");
        chk("t5_opc2", 32'(r_opc_o), 32'h4);
        chk("t5_gnt3", 32'(gnt_o), 32'h8);
        expect_rsp(4'b1000);
        tick; drive(4'b0001, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t5_gnt0", 32'(gnt_o), 32'h1);
        expect_rsp(4'b0001);
        tick; drive(4'b0010, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t5_full_req", 32'(req_o), 32'h0);
        tick; drive('0, 1'b0, 1'b1, 1'b0, '0); #1;
        check_rsp("t5_rsp3");
        chk("t5_opc3", 32'(r_opc_o), 32'h0);
        tick; drive('0, 1'b0, 1'b1, 1'b0, '0); #1;
        check_rsp("t5_rsp0");
        tick; drive('0, 1'b0, 1'b0, 1'b0, '0);

        // T6: reset with two outstanding discards them and restarts the pointer.
        reset_dut;
        tick; drive(4'b0010, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t6_gnt1", 32'(gnt_o), 32'h2);
        tick; drive(4'b0100, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t6_gnt2", 32'(gnt_o), 32'h4);
        tick;
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0, 1'b0, '0);
        tick;
        rst_n = 1'b1;
        exp_q.delete();
        tick; drive(4'b1001, 1'b1, 1'b0, 1'b0, '0); #1;
        chk("t6_req", 32'(req_o), 32'h1);
        chk("t6_gnt0", 32'(gnt_o), 32'h1);
        chk_payload(0, "t6");
        expect_rsp(4'b0001);
        tick; drive('0, 1'b0, 1'b1, 1'b0, '0); #1;
        check_rsp("t6_rsp0");
        tick; drive('0, 1'b0, 1'b0, 1'b0, '0); #1;
        chk("t6_idle_rvalid", 32'(r_valid_o), 32'h0);

        // ---------------- final report ----------------
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
